// File: rtl/photonic_pkg.sv
// Shared definitions for the photonic data-plane blocks: TX FSM states and
// link-word field layout.
package photonic_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HEADER  = 3'd1,
        PAYLOAD = 3'd2,
        TRAILER = 3'd3,
        DONE    = 3'd4
    } tx_state_e;

    localparam int WORD_W  = 32;
    localparam int FIELD_W = 16;

    // Every link word is two 16-bit fields: tag/index high, value low.
    localparam int HDR_DEST_LSB = 16;
    localparam int HDR_CNT_LSB  = 0;
    localparam int PLD_IDX_LSB  = 16;
    localparam int PLD_DATA_LSB = 0;
    localparam int TRL_TAG_LSB  = 16;
    localparam int TRL_PAR_LSB  = 0;

    localparam logic [FIELD_W-1:0] TRAILER_TAG = 16'hFFFF;

endpackage

// File: rtl/data_plane_tx_if.sv
// Control-plane request, GPP stack and link handshake bundle for data_plane_tx.
interface data_plane_tx_if #(parameter int ID_W = 16);
    logic                data_tx_flag;
    logic [ID_W-1:0]     dest_node_id;
    logic [ID_W-1:0]     stack_pointer;
    logic [ID_W-1:0]     top_of_stack;
    logic                stack_pop;
    logic [31:0]         data_tx_packet;
    logic                data_tx_valid;
    logic                data_tx_ready;
    logic                data_tx_complete_flag;
    logic                busy;
    logic                tx_error;

    modport master (
        input  data_tx_flag, dest_node_id, stack_pointer, top_of_stack, data_tx_ready,
        output stack_pop, data_tx_packet, data_tx_valid, data_tx_complete_flag, busy, tx_error
    );

    modport slave (
        output data_tx_flag, dest_node_id, stack_pointer, top_of_stack, data_tx_ready,
        input  stack_pop, data_tx_packet, data_tx_valid, data_tx_complete_flag, busy, tx_error
    );
endinterface

// File: rtl/data_plane_tx.sv
// Packetises the GPP stack onto the data link: header, payload words, optional
// parity trailer (enabled by defining DATA_TX_PARITY_EN), then a complete pulse.
module data_plane_tx
    import photonic_pkg::*;
#(
    parameter int MAX_WORDS = 256,
    parameter int ID_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ID_W-1:0]  node_id,
    input  logic [ID_W-1:0]  max_node,
    data_plane_tx_if.master  tx
);

    localparam logic [ID_W-1:0] MAX_CNT = ID_W'(MAX_WORDS);

`ifdef DATA_TX_PARITY_EN
    localparam tx_state_e TAIL_STATE = TRAILER;
`else
    localparam tx_state_e TAIL_STATE = DONE;
`endif

    tx_state_e         state_q, state_d;
    logic [ID_W-1:0]   dest_q, count_q, idx_q;
    logic              tx_error_q;
    logic              start_ok, start_bad, pop, valid, complete, last_word, dest_bad;
    logic [WORD_W-1:0] pkt;
    logic [ID_W-1:0]   count_in;
`ifdef DATA_TX_PARITY_EN
    logic [ID_W-1:0]   parity_q;
`endif

    assign dest_bad  = (tx.dest_node_id == '0) || (tx.dest_node_id == node_id) ||
                       (tx.dest_node_id > max_node);
    assign count_in  = (tx.stack_pointer > MAX_CNT) ? MAX_CNT : tx.stack_pointer;
    assign last_word = (idx_q + ID_W'(1)) == count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Packet word is built combinationally so the payload field tracks the
    // stack top the cycle after each pop, and stays put while the link stalls.
    always_comb begin
        state_d   = state_q;
        pkt       = '0;
        valid     = 1'b0;
        pop       = 1'b0;
        complete  = 1'b0;
        start_ok  = 1'b0;
        start_bad = 1'b0;
        case (state_q)
            IDLE: begin
                if (tx.data_tx_flag) begin
                    if (dest_bad) begin
                        start_bad = 1'b1;
                    end else begin
                        start_ok = 1'b1;
                        state_d  = HEADER;
                    end
                end
            end
            HEADER: begin
                valid = 1'b1;
                pkt[HDR_DEST_LSB +: FIELD_W] = FIELD_W'(dest_q);
                pkt[HDR_CNT_LSB  +: FIELD_W] = FIELD_W'(count_q);
                if (tx.data_tx_ready) state_d = (count_q == '0) ? TAIL_STATE : PAYLOAD;
            end
            PAYLOAD: begin
                valid = 1'b1;
                pkt[PLD_IDX_LSB  +: FIELD_W] = FIELD_W'(idx_q);
                pkt[PLD_DATA_LSB +: FIELD_W] = FIELD_W'(tx.top_of_stack);
                pop   = tx.data_tx_ready;
                if (tx.data_tx_ready && last_word) state_d = TAIL_STATE;
            end
            TRAILER: begin
`ifdef DATA_TX_PARITY_EN
                valid = 1'b1;
                pkt[TRL_TAG_LSB +: FIELD_W] = TRAILER_TAG;
                pkt[TRL_PAR_LSB +: FIELD_W] = FIELD_W'(parity_q);
                if (tx.data_tx_ready) state_d = DONE;
`else
                state_d = IDLE;
`endif
            end
            DONE: begin
                complete = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dest_q     <= '0;
            count_q    <= '0;
            idx_q      <= '0;
            tx_error_q <= 1'b0;
`ifdef DATA_TX_PARITY_EN
            parity_q   <= '0;
`endif
        end else begin
            tx_error_q <= start_bad;
            if (start_ok) begin
                dest_q  <= tx.dest_node_id;
                count_q <= count_in;
                idx_q   <= '0;
`ifdef DATA_TX_PARITY_EN
                parity_q <= '0;
`endif
            end
            if (pop) begin
                idx_q <= idx_q + ID_W'(1);
`ifdef DATA_TX_PARITY_EN
                parity_q <= parity_q ^ tx.top_of_stack;
`endif
            end
        end
    end

    assign tx.data_tx_packet        = pkt;
    assign tx.data_tx_valid         = valid;
    assign tx.stack_pop             = pop;
    assign tx.data_tx_complete_flag = complete;
    assign tx.busy                  = (state_q != IDLE);
    assign tx.tx_error              = tx_error_q;

endmodule

// File: doc/data_plane_tx.md
DATA_PLANE_TX -- requirements
Module: data_plane_tx

Interface
REQ-001 The block SHALL have parameter MAX_WORDS, default 256, giving the largest payload word count per packet.
REQ-002 The block SHALL have parameter ID_W, default 16, giving the node-id and count field width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 The block SHALL have port node_id, input, 16 bits: the local node id.
REQ-006 The block SHALL have port max_node, input, 16 bits: the highest valid node id.
REQ-007 The block SHALL have port data_tx_flag, input, 1 bit: the start request from control_plane (data_tx_flag_out).
REQ-008 The block SHALL have port dest_node_id, input, 16 bits: the destination node, sampled with the start request.
REQ-009 The block SHALL have port stack_pointer, input, 16 bits: the GPP stack depth, used as the payload word count.
REQ-010 The block SHALL have port top_of_stack, input, 16 bits: the current top word of the GPP stack.
REQ-011 The block SHALL have port stack_pop, output, 1 bit: a one-cycle pop strobe to the GPP stack.
REQ-012 The block SHALL have port data_tx_packet, output, 32 bits: the outgoing link word.
REQ-013 The block SHALL have port data_tx_valid, output, 1 bit: data_tx_packet holds a valid word.
REQ-014 The block SHALL have port data_tx_ready, input, 1 bit: the link accepts the word this cycle.
REQ-015 The block SHALL have port data_tx_complete_flag, output, 1 bit: a one-cycle pulse after the last word is accepted.
REQ-016 The block SHALL have ports busy (output, 1 bit, packet in progress) and tx_error (output, 1 bit, one-cycle pulse when a request is rejected).

Function
REQ-017 The FSM SHALL have states IDLE, HEADER, PAYLOAD, TRAILER, DONE.
REQ-018 In IDLE, data_tx_flag=1 SHALL latch dest_node_id and count=min(stack_pointer, MAX_WORDS), then go to HEADER; data_tx_valid SHALL be 1 from the next cycle.
REQ-019 If dest_node_id is 0, equals node_id, or exceeds max_node, the request SHALL be dropped: tx_error pulses one cycle, the FSM stays in IDLE, and no word is sent.
REQ-020 The header word SHALL be {dest[15:0], count[15:0]}; payload word i (0-based) SHALL be {i[15:0], top_of_stack}.
REQ-021 A word SHALL transfer only when data_tx_valid and data_tx_ready are both 1; data_tx_packet SHALL hold stable while data_tx_valid=1 and data_tx_ready=0.
REQ-022 Each accepted payload word SHALL assert stack_pop for exactly that cycle; top_of_stack SHALL be sampled for the next word no earlier than the following cycle.
REQ-023 After the header, count=0 SHALL skip PAYLOAD; after the last payload word (or the header when count=0), the FSM SHALL go to TRAILER if enabled, else DONE.
REQ-024 DONE SHALL pulse data_tx_complete_flag for one cycle, deassert busy, and return to IDLE; the earliest new start is accepted the following cycle.
REQ-025 data_tx_flag SHALL be ignored while busy=1, and a start asserted in the DONE cycle SHALL also be ignored.
REQ-026 busy SHALL be 1 from HEADER through DONE inclusive.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, with stack_pop, data_tx_valid, data_tx_complete_flag, busy and tx_error all 0 and data_tx_packet 32'h0.
REQ-028 Reset mid-packet SHALL abort the packet with no complete pulse and no further pops.

Configuration
REQ-029 When DATA_TX_PARITY_EN is defined, TRAILER SHALL send {16'hFFFF, XOR of all payload data fields} (16'h0000 when count=0).
REQ-030 When DATA_TX_PARITY_EN is undefined, the TRAILER state SHALL be unreachable and no trailer word sent.

Structure
REQ-031 The state enum, header/payload/trailer field offsets and the TRAILER_TAG (16'hFFFF) constant SHALL live in the shared package photonic_pkg.
REQ-032 The block SHALL be a single module with no sub-module.

Verification
REQ-033 The bench SHALL cover: node_id=1, max_node=4, dest=3, stack_pointer=2, TOS=16'hA5 then 16'h5A, ready=1 -> words 32'h00030002, 32'h000000A5, 32'h0001005A, two stack_pop pulses, complete pulse.
REQ-034 The bench SHALL cover: same packet with ready=0 for 3 cycles at the first payload word -> word held stable, no pop until accepted.
REQ-035 The bench SHALL cover: dest=1 (equal to node_id), then dest=5 (above max_node) -> tx_error pulse each time, valid never 1.
REQ-036 The bench SHALL cover: stack_pointer=0 -> only header 32'h00030000, then complete (with DATA_TX_PARITY_EN: trailer 32'hFFFF0000).
REQ-037 The bench SHALL cover: rst_n low during the second payload word -> all outputs 0 at once, no complete pulse, new packet accepted after release.
REQ-038 The bench SHALL cover: with DATA_TX_PARITY_EN, data 16'hA5 and 16'h5A -> trailer 32'hFFFF00FF.
